conv_weight_sched: RTL and testbench
====================================

Name: conv_weight_sched

Overview:
- Per-layer sequencer for one convolution pass.
- Accepts a start command and drives the weight address generator's enable and clear.
- Gates progress on input-pixel availability, frames accumulator clear/valid strobes per output pixel, and drains the MAC pipeline.
- Sits between the layer-level control FSM and the weight address generator / MAC array.

Parameters:
- NUM_ONE_PIXEL_CYCLE, 9, MAC cycles per output pixel (weight pairs per pixel).
- OUT_FEATURE_WIDTH, 4, output feature map side; pixels per group = OUT_FEATURE_WIDTH squared.
- NUM_ONEMULT, 2, output feature maps computed serially per multiplier (groups).
- PIPE_LATENCY, 3, cycles from the last MAC enable of a pixel to the accumulator result being valid (at least 1).
- CYC_BITWIDTH, 4, width of the cycle counter.
- OUTPIXEL_BITWIDTH, 4, width of the pixel counter.
- NUM_MULTCOMP_BITWIDTH, 1, width of the group counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a pass; ignored unless IDLE
- abort  in  1  synchronous abort; returns to IDLE
- in_ready  in  1  input feature operands available this cycle
- wgen_clear  out  1  one-cycle synchronous clear to the weight address generator
- wgen_enable  out  1  advance weight address generator / MAC this cycle
- acc_clear  out  1  accumulator clear, aligned with the first MAC cycle of each pixel
- acc_valid  out  1  accumulator result valid, one cycle per output pixel
- pix_idx  out  OUTPIXEL_BITWIDTH  output pixel index tagged to acc_valid
- grp_idx  out  NUM_MULTCOMP_BITWIDTH  group index tagged to acc_valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0; delay line cleared.
- States: IDLE, PREP, RUN, DRAIN, DONE.
- IDLE: on start go to PREP.
- PREP: one cycle; wgen_clear=1; counters zeroed; go to RUN.
- RUN: wgen_enable = in_ready (combinational from state and in_ready).
  - When in_ready=0: hold all counters; no strobes.
  - acc_clear = wgen_enable AND cyc==0.
  - On each enabled cycle, cyc increments.
  - At cyc==NUM_ONE_PIXEL_CYCLE-1 (enabled): cyc wraps to 0; a pixel-end token {pix, grp} enters the PIPE_LATENCY-deep delay line; pix increments.
  - When pix is at its maximum (OUT_FEATURE_WIDTH squared minus 1), pix wraps to 0 and grp increments.
  - On the last cycle of the last pixel of the last group: go to DRAIN.
- Delay line: each token emerges exactly PIPE_LATENCY cycles after entry as acc_valid=1 with pix_idx/grp_idx. The delay line advances every cycle regardless of in_ready.
  - Back-to-back pixels with NUM_ONE_PIXEL_CYCLE=1 must produce consecutive acc_valid pulses.
- DRAIN: wgen_enable=0; stay until the delay line is empty, i.e. the last acc_valid has been emitted; then go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- pix_idx and grp_idx are 0 whenever acc_valid=0.
- start while busy: ignored, with no effect on counters.
- abort: from any non-IDLE state, next state is IDLE.
  - Counters and delay line cleared; no done; no pending acc_valid emitted.
  - abort has priority over start in the same cycle.
- Async reset mid-pass: immediate return to the reset values above.
- Widths: counters compare against parameter products computed at full integer width; no overflow inside a pass.
- Latency, start to first wgen_enable: 2 cycles, given in_ready=1.
- Pass length with in_ready always 1:
  - Total enabled cycles = NUM_ONE_PIXEL_CYCLE × pixels per group × NUM_ONEMULT.
  - done asserts PIPE_LATENCY+1 cycles after the last enabled cycle.

Optional Feature:
- Macro CONV_SCHED_PERF_CNT_EN.
- When defined:
  - Extra outputs stall_cnt[15:0] and run_cnt[15:0], cleared in PREP.
  - run_cnt counts RUN cycles; stall_cnt counts RUN cycles with in_ready=0.
  - Both saturate at 16'hFFFF and hold their values after done until the next start.
- When undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package/header:
  - State encoding constants: IDLE=0, PREP=1, RUN=2, DRAIN=3, DONE=4.
  - Default layer constants: NUM_ONE_PIXEL_CYCLE, OUT_FEATURE_WIDTH, NUM_ONEMULT, widths.
- One sub-module: conv_sched_delay_line, a parameterised shift register of {valid, pix, grp}, depth PIPE_LATENCY, with synchronous flush and an empty flag.

Test Plan:
- Defaults, in_ready=1, single start → wgen_clear at cycle 1; wgen_enable high for 9×16×2=288 consecutive cycles; 32 acc_valid pulses with pix_idx 0..15 per grp 0,1; first acc_valid 3 cycles after the 9th enable; done 4 cycles after the last enable.
- in_ready toggling 1,0 every cycle → counters freeze on 0 cycles; acc_clear only on enabled cyc==0; still 32 acc_valid in order; with CONV_SCHED_PERF_CNT_EN, stall_cnt equals the number of in_ready=0 RUN cycles.
- NUM_ONE_PIXEL_CYCLE=1, PIPE_LATENCY=1 → acc_valid high on consecutive cycles with incrementing pix_idx.
- Second start during RUN → ignored; totals unchanged; exactly one done.
- abort at the 100th enabled cycle → next cycle IDLE, busy=0, no further acc_valid or done; a subsequent start runs a full clean pass.
- reset asserted mid-DRAIN → all outputs 0 immediately; no done pulse after reset release.

Source files
------------

// File: rtl/conv_weight_sched_pkg.sv
// -----------------------------------------------------------------------------
// conv_weight_sched_pkg
//
// Shared definitions for the convolution pass sequencer:
//   - state_t   : sequencer state encoding (IDLE=0, PREP=1, RUN=2, DRAIN=3,
//                 DONE=4)
//   - DEF_*     : default layer geometry and counter widths
//   - pixels_per_group() : output pixels produced per output feature map
// -----------------------------------------------------------------------------
package conv_weight_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Default layer geometry.
   localparam int DEF_NUM_ONE_PIXEL_CYCLE   = 9;  // MAC cycles per output pixel
   localparam int DEF_OUT_FEATURE_WIDTH     = 4;  // output feature map side
   localparam int DEF_NUM_ONEMULT           = 2;  // feature maps per multiplier
   localparam int DEF_PIPE_LATENCY          = 3;  // last MAC to result valid

   // Default counter widths.
   localparam int DEF_CYC_BITWIDTH          = 4;
   localparam int DEF_OUTPIXEL_BITWIDTH     = 4;
   localparam int DEF_NUM_MULTCOMP_BITWIDTH = 1;

   // Pixels in one output feature map, evaluated at full integer width so the
   // counter compares never truncate.
   function automatic int pixels_per_group(input int side);
      return side * side;
   endfunction

endpackage

// File: rtl/conv_sched_delay_line.sv
// -----------------------------------------------------------------------------
// conv_sched_delay_line
//
// Fixed-latency shift register carrying pixel-end tokens {valid, pix, grp}
// from the last MAC enable of a pixel to the cycle its accumulator result is
// valid. A token written in cycle t is presented on the outputs in cycle
// t+DEPTH. The line shifts every cycle; nothing stalls it.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_flush      synchronous clear of every stage (wins over i_valid)
//   i_valid      token entering this cycle
//   i_pix/i_grp  token payload
//   o_valid      token leaving this cycle
//   o_pix/o_grp  payload of the leaving token, 0 when o_valid is 0
//   o_empty      no token is held behind the output stage, i.e. the line is
//                clear once the current output has been emitted
// -----------------------------------------------------------------------------
module conv_sched_delay_line #(
   parameter int DEPTH = 3,
   parameter int PIX_W = 4,
   parameter int GRP_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [PIX_W-1:0] i_pix,
   input  logic [GRP_W-1:0] i_grp,
   output logic             o_valid,
   output logic [PIX_W-1:0] o_pix,
   output logic [GRP_W-1:0] o_grp,
   output logic             o_empty
);

   typedef struct packed {
      logic             valid;
      logic [PIX_W-1:0] pix;
      logic [GRP_W-1:0] grp;
   } tok_t;

   tok_t r_stage [DEPTH];
   tok_t w_tok_in;
   logic w_empty;

   // Payload is zeroed for empty slots so the outputs read 0 between tokens.
   assign w_tok_in = i_valid ? '{valid: 1'b1, pix: i_pix, grp: i_grp} : '0;

   // NOTE: every stage is reset and flushed, not just the valid bits; a stale
   // payload would otherwise leak onto o_pix/o_grp.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage sample its
         // predecessor's old value, giving a true shift in one edge.
         r_stage[0] <= w_tok_in;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   // Only the stages behind the output matter: the output stage itself is
   // being emitted this cycle.
   always_comb begin
      // NOTE: default assignment first so no path leaves w_empty unassigned
      // (which would infer a latch).
      w_empty = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (r_stage[i].valid) begin
            w_empty = 1'b0;
         end
      end
   end

   assign o_valid = r_stage[DEPTH-1].valid;
   assign o_pix   = r_stage[DEPTH-1].pix;
   assign o_grp   = r_stage[DEPTH-1].grp;
   assign o_empty = w_empty;

endmodule

// File: rtl/conv_weight_sched.sv
// -----------------------------------------------------------------------------
// conv_weight_sched
//
// Per-layer sequencer for one convolution pass. On start it clears the weight
// address generator, then enables it (and the MAC array) on every cycle input
// operands are available, framing accumulator clear per output pixel and
// emitting acc_valid with the pixel/group tag PIPE_LATENCY cycles after each
// pixel's last MAC. After the last pixel of the last group it drains the MAC
// pipeline and pulses done.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   start         one-cycle pulse, begins a pass (only honoured in IDLE)
//   abort         synchronous abort back to IDLE, drops in-flight results
//   in_ready      input feature operands available this cycle
//   wgen_clear    one-cycle clear to the weight address generator
//   wgen_enable   advance weight address generator / MAC this cycle
//   acc_clear     accumulator clear on the first MAC cycle of each pixel
//   acc_valid     accumulator result valid, one cycle per output pixel
//   pix_idx       pixel index of the valid result (0 otherwise)
//   grp_idx       group index of the valid result (0 otherwise)
//   busy          high in every state except IDLE
//   done          one-cycle pulse at the end of a pass
//
// Build option CONV_SCHED_PERF_CNT_EN adds:
//   run_cnt       RUN cycles of the current/last pass (saturating)
//   stall_cnt     RUN cycles with in_ready low (saturating)
// -----------------------------------------------------------------------------
module conv_weight_sched
   import conv_weight_sched_pkg::*;
#(
   parameter int NUM_ONE_PIXEL_CYCLE   = DEF_NUM_ONE_PIXEL_CYCLE,
   parameter int OUT_FEATURE_WIDTH     = DEF_OUT_FEATURE_WIDTH,
   parameter int NUM_ONEMULT           = DEF_NUM_ONEMULT,
   parameter int PIPE_LATENCY          = DEF_PIPE_LATENCY,
   parameter int CYC_BITWIDTH          = DEF_CYC_BITWIDTH,
   parameter int OUTPIXEL_BITWIDTH     = DEF_OUTPIXEL_BITWIDTH,
   parameter int NUM_MULTCOMP_BITWIDTH = DEF_NUM_MULTCOMP_BITWIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             abort,
   input  logic                             in_ready,
   output logic                             wgen_clear,
   output logic                             wgen_enable,
   output logic                             acc_clear,
   output logic                             acc_valid,
   output logic [OUTPIXEL_BITWIDTH-1:0]     pix_idx,
   output logic [NUM_MULTCOMP_BITWIDTH-1:0] grp_idx,
   output logic                             busy,
   output logic                             done
`ifdef CONV_SCHED_PERF_CNT_EN
   ,
   output logic [15:0]                      stall_cnt,
   output logic [15:0]                      run_cnt
`endif
);

   localparam int PIX_PER_GRP = pixels_per_group(OUT_FEATURE_WIDTH);

   state_t r_state;
   state_t w_next_state;

   logic [CYC_BITWIDTH-1:0]          r_cyc;
   logic [OUTPIXEL_BITWIDTH-1:0]     r_pix;
   logic [NUM_MULTCOMP_BITWIDTH-1:0] r_grp;

   logic w_enable;
   logic w_cyc_last;
   logic w_pix_last;
   logic w_grp_last;
   logic w_pixel_end;
   logic w_pass_end;
   logic w_line_empty;

   // --------------------------------------------------------------------------
   // Progress decode
   // --------------------------------------------------------------------------
   assign w_enable    = (r_state == ST_RUN) && in_ready;
   assign w_cyc_last  = (int'(r_cyc) == NUM_ONE_PIXEL_CYCLE - 1);
   assign w_pix_last  = (int'(r_pix) == PIX_PER_GRP - 1);
   assign w_grp_last  = (int'(r_grp) == NUM_ONEMULT - 1);
   assign w_pixel_end = w_enable && w_cyc_last;
   assign w_pass_end  = w_pixel_end && w_pix_last && w_grp_last;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state
   // --------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (start)        w_next_state = ST_PREP;
         ST_PREP:                    w_next_state = ST_RUN;
         ST_RUN:   if (w_pass_end)   w_next_state = ST_DRAIN;
         ST_DRAIN: if (w_line_empty) w_next_state = ST_DONE;
         ST_DONE:                    w_next_state = ST_IDLE;
         default:                    w_next_state = ST_IDLE;
      endcase
      // Abort overrides everything, including a start seen in the same cycle.
      if (abort) begin
         w_next_state = ST_IDLE;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------------
   always_comb begin
      wgen_clear  = 1'b0;
      wgen_enable = 1'b0;
      acc_clear   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_PREP: begin
            wgen_clear = 1'b1;
            busy       = 1'b1;
         end
         ST_RUN: begin
            wgen_enable = in_ready;
            acc_clear   = in_ready && (r_cyc == '0);
            busy        = 1'b1;
         end
         ST_DRAIN: begin
            busy = 1'b1;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Cycle / pixel / group counters. They only move on enabled RUN cycles, so
   // a start seen outside IDLE cannot disturb them. The final pixel returns
   // every counter to 0 instead of letting the group counter overflow.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cyc <= '0;
         r_pix <= '0;
         r_grp <= '0;
      end else if (abort || (r_state == ST_PREP)) begin
         r_cyc <= '0;
         r_pix <= '0;
         r_grp <= '0;
      end else if (w_enable) begin
         if (w_cyc_last) begin
            r_cyc <= '0;
            if (w_pix_last) begin
               r_pix <= '0;
               r_grp <= w_grp_last ? '0 : r_grp + 1'b1;
            end else begin
               r_pix <= r_pix + 1'b1;
            end
         end else begin
            r_cyc <= r_cyc + 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Pixel-end tokens ride the MAC pipeline latency and surface as acc_valid.
   // --------------------------------------------------------------------------
   conv_sched_delay_line #(
      .DEPTH (PIPE_LATENCY),
      .PIX_W (OUTPIXEL_BITWIDTH),
      .GRP_W (NUM_MULTCOMP_BITWIDTH)
   ) u_delay_line (
      .clk     (clk),
      .reset   (reset),
      .i_flush (abort),
      .i_valid (w_pixel_end),
      .i_pix   (r_pix),
      .i_grp   (r_grp),
      .o_valid (acc_valid),
      .o_pix   (pix_idx),
      .o_grp   (grp_idx),
      .o_empty (w_line_empty)
   );

`ifdef CONV_SCHED_PERF_CNT_EN
   // --------------------------------------------------------------------------
   // Performance counters: cleared when a pass starts, saturating, and left
   // untouched outside RUN so the totals stay readable after done.
   // --------------------------------------------------------------------------
   logic [15:0] r_run_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run_cnt   <= '0;
         r_stall_cnt <= '0;
      end else if (r_state == ST_PREP) begin
         r_run_cnt   <= '0;
         r_stall_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         if (r_run_cnt != 16'hFFFF) begin
            r_run_cnt <= r_run_cnt + 16'd1;
         end
         if (!in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign run_cnt   = r_run_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_weight_sched.sv
// -----------------------------------------------------------------------------
// tb_conv_weight_sched
//
// Two sequencer instances: u_dut0 with the default geometry (9 MAC cycles per
// pixel, latency 3) and u_dut1 with 1 MAC cycle per pixel and latency 1.
// A per-pass driver models the pass from its rules (enabled-cycle counting),
// checks the control strobes every cycle and pushes each expected result
// {dut, pix, grp, due cycle} into a scoreboard queue; an independent monitor
// compares every acc_valid against the queue head.
// -----------------------------------------------------------------------------
module tb_conv_weight_sched;

   localparam int PPG  = 16;   // pixels per group (4 x 4)
   localparam int NGRP = 2;    // groups per pass

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tb_cycle = 0;
   always @(posedge clk) tb_cycle++;

   logic       reset;
   logic [1:0] start;
   logic [1:0] abort;
   logic [1:0] in_ready;
   logic [1:0] wgen_clear;
   logic [1:0] wgen_enable;
   logic [1:0] acc_clear;
   logic [1:0] acc_valid;
   logic [1:0][3:0] pix_idx;
   logic [1:0] grp_idx;
   logic [1:0] busy;
   logic [1:0] done;
`ifdef CONV_SCHED_PERF_CNT_EN
   logic [1:0][15:0] stall_cnt;
   logic [1:0][15:0] run_cnt;
`endif

   conv_weight_sched u_dut0 (
      .clk         (clk),
      .reset       (reset),
      .start       (start[0]),
      .abort       (abort[0]),
      .in_ready    (in_ready[0]),
      .wgen_clear  (wgen_clear[0]),
      .wgen_enable (wgen_enable[0]),
      .acc_clear   (acc_clear[0]),
      .acc_valid   (acc_valid[0]),
      .pix_idx     (pix_idx[0]),
      .grp_idx     (grp_idx[0:0]),
      .busy        (busy[0]),
      .done        (done[0])
`ifdef CONV_SCHED_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt[0]),
      .run_cnt     (run_cnt[0])
`endif
   );

   conv_weight_sched #(
      .NUM_ONE_PIXEL_CYCLE (1),
      .PIPE_LATENCY        (1)
   ) u_dut1 (
      .clk         (clk),
      .reset       (reset),
      .start       (start[1]),
      .abort       (abort[1]),
      .in_ready    (in_ready[1]),
      .wgen_clear  (wgen_clear[1]),
      .wgen_enable (wgen_enable[1]),
      .acc_clear   (acc_clear[1]),
      .acc_valid   (acc_valid[1]),
      .pix_idx     (pix_idx[1]),
      .grp_idx     (grp_idx[1:1]),
      .busy        (busy[1]),
      .done        (done[1])
`ifdef CONV_SCHED_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt[1]),
      .run_cnt     (run_cnt[1])
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, tb_cycle, act, exp);
      end
   endtask

   // --------------------------------------------------------------------------
   // Scoreboard of expected acc_valid results.
   // --------------------------------------------------------------------------
   typedef struct {
      int w;
      int pix;
      int grp;
      int due;
   } tok_t;

   tok_t sbq[$];
   bit   mon_on = 1'b0;

   always @(negedge clk) begin
      bit   exp_v;
      tok_t t;
      if (mon_on) begin
         for (int w = 0; w < 2; w++) begin
            exp_v = (sbq.size() > 0) && (sbq[0].due == tb_cycle) && (sbq[0].w == w);
            check($sformatf("acc_valid[%0d]", w), int'(acc_valid[w]), int'(exp_v));
            if (exp_v) begin
               t = sbq.pop_front();
               if (acc_valid[w]) begin
                  check($sformatf("pix_idx[%0d]", w), int'(pix_idx[w]), t.pix);
                  check($sformatf("grp_idx[%0d]", w), int'(grp_idx[w]), t.grp);
               end
            end else if (!acc_valid[w]) begin
               check($sformatf("pix_idx_idle[%0d]", w), int'(pix_idx[w]), 0);
               check($sformatf("grp_idx_idle[%0d]", w), int'(grp_idx[w]), 0);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // One pass on instance w.
   //   mode      0: in_ready always 1, 1: toggles 1,0, 2: random (75% high)
   //   abort_at  assert abort on this enabled cycle (0 = never)
   //   dup_at    pulse a second start on this enabled cycle (0 = never)
   //   rst_drain assert reset two cycles after the last enabled cycle
   // --------------------------------------------------------------------------
   task automatic run_pass(input int w, input int mode, input int abort_at,
                           input int dup_at, input bit rst_drain);
      int npc, lat, total_en, en_cnt, last_k, dead_from, run_cyc, stall_cyc, k;
      bit rdy, in_run, exp_wen, exp_aclr, exp_done, exp_busy, dead;
      bit aborted, dup_done, finished;
      tok_t t;
      npc       = (w == 0) ? 9 : 1;
      lat       = (w == 0) ? 3 : 1;
      total_en  = npc * PPG * NGRP;
      en_cnt    = 0;
      last_k    = -1;
      dead_from = 1 << 30;
      run_cyc   = 0;
      stall_cyc = 0;
      aborted   = 1'b0;
      dup_done  = 1'b0;
      finished  = 1'b0;
      k         = 0;
      while (!finished && (k < 2000)) begin
         @(posedge clk);
         #1;
         if (rst_drain && (last_k >= 0) && (k == last_k + 2)) begin
            reset = 1'b1;
            sbq.delete();
            dead_from = k;
         end
         if (rst_drain && (k == dead_from + 2)) reset = 1'b0;
         if (aborted && (k == dead_from)) sbq.delete();
         dead = (k >= dead_from);

         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (k % 2 == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase

         in_run   = !dead && (k >= 2) && (en_cnt < total_en);
         exp_wen  = in_run && rdy;
         exp_aclr = exp_wen && (en_cnt % npc == 0);
         if (in_run) begin
            run_cyc++;
            if (!rdy) stall_cyc++;
         end
         if (exp_wen) begin
            en_cnt++;
            if (en_cnt % npc == 0) begin
               t.w   = w;
               t.pix = (en_cnt / npc - 1) % PPG;
               t.grp = (en_cnt / npc - 1) / PPG;
               t.due = tb_cycle + lat;
               sbq.push_back(t);
            end
            if (en_cnt == total_en) last_k = k;
         end
         exp_done = !dead && (last_k >= 0) && (k == last_k + lat + 1);
         exp_busy = !dead && (k >= 1) && ((last_k < 0) || (k <= last_k + lat + 1));

         in_ready[w] = rdy;
         abort[w]    = 1'b0;
         if (!dead && (abort_at > 0) && exp_wen && (en_cnt == abort_at)) begin
            abort[w]  = 1'b1;
            aborted   = 1'b1;
            dead_from = k + 1;
         end
         start[w] = (k == 0);
         if ((dup_at > 0) && !dup_done && exp_wen && (en_cnt == dup_at)) begin
            start[w] = 1'b1;
            dup_done = 1'b1;
         end

         @(negedge clk);
         check("wgen_clear",  int'(wgen_clear[w]),  int'(!dead && (k == 1)));
         check("wgen_enable", int'(wgen_enable[w]), int'(exp_wen));
         check("acc_clear",   int'(acc_clear[w]),   int'(exp_aclr));
         check("busy",        int'(busy[w]),        int'(exp_busy));
         check("done",        int'(done[w]),        int'(exp_done));

         if (dead && (k >= dead_from + 6)) finished = 1'b1;
         if (!dead && (last_k >= 0) && (k == last_k + lat + 2)) finished = 1'b1;
         k++;
      end
      start[w]    = 1'b0;
      abort[w]    = 1'b0;
      in_ready[w] = 1'b0;
      check("pass_finished", int'(finished), 1);
      check("scoreboard_drained", sbq.size(), 0);
`ifdef CONV_SCHED_PERF_CNT_EN
      if (!dead) begin
         check("run_cnt",   int'(run_cnt[w]),   run_cyc);
         check("stall_cnt", int'(stall_cnt[w]), stall_cyc);
      end
`endif
   endtask

   initial begin
      reset    = 1'b1;
      start    = '0;
      abort    = '0;
      in_ready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         check("rst_wgen_clear",  int'(wgen_clear[w]),  0);
         check("rst_wgen_enable", int'(wgen_enable[w]), 0);
         check("rst_acc_clear",   int'(acc_clear[w]),   0);
         check("rst_acc_valid",   int'(acc_valid[w]),   0);
         check("rst_pix_idx",     int'(pix_idx[w]),     0);
         check("rst_grp_idx",     int'(grp_idx[w]),     0);
         check("rst_busy",        int'(busy[w]),        0);
         check("rst_done",        int'(done[w]),        0);
`ifdef CONV_SCHED_PERF_CNT_EN
         check("rst_run_cnt",     int'(run_cnt[w]),     0);
         check("rst_stall_cnt",   int'(stall_cnt[w]),   0);
`endif
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_on = 1'b1;

      run_pass(0, 0, 0,   0,  1'b0);   // full pass, in_ready always high
      run_pass(0, 1, 0,   0,  1'b0);   // in_ready toggling 1,0
      run_pass(1, 0, 0,   0,  1'b0);   // 1 cycle per pixel, latency 1
      run_pass(0, 2, 0,   50, 1'b0);   // random stalls, second start ignored
      run_pass(0, 0, 100, 0,  1'b0);   // abort on the 100th enabled cycle
      run_pass(0, 0, 0,   0,  1'b0);   // clean pass after abort
      run_pass(0, 0, 0,   0,  1'b1);   // reset mid-DRAIN
      run_pass(0, 0, 0,   0,  1'b0);   // clean pass after reset
      run_pass(1, 2, 0,   7,  1'b0);   // random stalls on the short config

      repeat (3) @(posedge clk);
      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
